// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer
// Issues 8259-style command sequences (ICW init, single OCW, IRR/ISR/IMR
// reads) as fixed 5-clock bus cycles: SETUP, STROBE x2, HOLD, GAP.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   init_start, icw1-4  request the ICW sequence; words sampled on accept
//   ocw_start, ocw_sel, ocw_data   request one OCW (sel 1..3)
//   rd_start, rd_sel    request a register read (0=IRR, 1=ISR, 2=IMR)
//   dataBus_in/out/oe   PIC data bus (oe=1 drives the bus)
//   A0, CS, WR, RD      PIC control pins, CS/WR/RD active-low
//   busy, done, init_done, err     status (done/err are one-cycle pulses)
//   rd_data, rd_valid   captured read data and its one-cycle qualifier
//
// state  | meaning
// IDLE   | waiting for a start request
// SETUP  | CS low, A0 and write data presented, no strobe yet
// STROBE | WR or RD low, two clocks; read data captured on the second
// HOLD   | strobe released, CS and data still held
// GAP    | CS released; next word or back to IDLE
module pic_cmd_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       ocw_start,
    input  logic [1:0] ocw_sel,
    input  logic [7:0] ocw_data,
    input  logic       rd_start,
    input  logic [1:0] rd_sel,
    input  logic [7:0] dataBus_in,
    output logic [7:0] dataBus_out,
    output logic       dataBus_oe,
    output logic       A0,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       busy,
    output logic       done,
    output logic       init_done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state;
    logic [1:0]      step;
    logic [1:0]      last_step;
    logic            strobe_second;
    logic            seq_init;
    logic [3:0][7:0] word_data;
    logic [3:0]      word_a0;
    logic [3:0]      word_rd;

    // Request decode, only acted on in IDLE
    logic            accept;
    logic            reject;
    logic            new_init;
    logic [1:0]      new_last;
    logic [3:0][7:0] new_data;
    logic [3:0]      new_a0;
    logic [3:0]      new_rd;
    logic [1:0]      n;
    logic [1:0]      next_step;
    logic            any_start;

    assign next_step = step + 2'd1;
    assign any_start = init_start | ocw_start | rd_start;

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        new_init = 1'b0;
        new_last = 2'd0;
        new_data = '0;
        new_a0   = '0;
        new_rd   = '0;
        n        = 2'd0;
        if (init_start) begin
            accept      = 1'b1;
            new_init    = 1'b1;
            reject      = ocw_start | rd_start;
            new_data[0] = icw1 | 8'h10;
            new_a0[0]   = 1'b0;
            new_data[1] = icw2;
            new_a0[1]   = 1'b1;
            n           = 2'd1;
            // icw1[1]=0 means cascade mode, which needs ICW3
            if (!icw1[1]) begin
                n           = n + 2'd1;
                new_data[n] = icw3;
                new_a0[n]   = 1'b1;
            end
            if (icw1[0]) begin
                n           = n + 2'd1;
                new_data[n] = icw4 & 8'h1F;
                new_a0[n]   = 1'b1;
            end
            new_last = n;
        end else if (ocw_start) begin
            reject = rd_start;
            if (!init_done || ocw_sel == 2'd0) begin
                reject = 1'b1;
            end else begin
                accept = 1'b1;
                case (ocw_sel)
                    2'd1: begin
                        new_data[0] = ocw_data;
                        new_a0[0]   = 1'b1;
                    end
                    2'd2: begin
                        new_data[0] = ocw_data & 8'hE7;
                        new_a0[0]   = 1'b0;
                    end
                    default: begin
                        new_data[0] = (ocw_data & 8'h6F) | 8'h08;
                        new_a0[0]   = 1'b0;
                    end
                endcase
            end
        end else if (rd_start) begin
            if (!init_done || rd_sel == 2'd3) begin
                reject = 1'b1;
            end else begin
                accept = 1'b1;
                if (rd_sel == 2'd2) begin
                    new_a0[0] = 1'b1;
                    new_rd[0] = 1'b1;
                end else begin
                    // IRR/ISR: select the register with OCW3 first
                    new_data[0] = (rd_sel == 2'd0) ? 8'h0A : 8'h0B;
                    new_a0[0]   = 1'b0;
                    new_a0[1]   = 1'b0;
                    new_rd[1]   = 1'b1;
                    new_last    = 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            step          <= 2'd0;
            last_step     <= 2'd0;
            strobe_second <= 1'b0;
            seq_init      <= 1'b0;
            word_data     <= '0;
            word_a0       <= '0;
            word_rd       <= '0;
            dataBus_out   <= 8'h00;
            dataBus_oe    <= 1'b0;
            A0            <= 1'b0;
            CS            <= 1'b1;
            WR            <= 1'b1;
            RD            <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            init_done     <= 1'b0;
            err           <= 1'b0;
            rd_data       <= 8'h00;
            rd_valid      <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            err      <= (state == ST_IDLE) ? reject : any_start;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        step      <= 2'd0;
                        last_step <= new_last;
                        seq_init  <= new_init;
                        word_data <= new_data;
                        word_a0   <= new_a0;
                        word_rd   <= new_rd;
                        busy      <= 1'b1;
                        if (new_init) begin
                            init_done <= 1'b0;
                        end
                        CS         <= 1'b0;
                        WR         <= 1'b1;
                        RD         <= 1'b1;
                        A0         <= new_a0[0];
                        dataBus_oe <= ~new_rd[0];
                        if (!new_rd[0]) begin
                            dataBus_out <= new_data[0];
                        end
                    end
                end
                ST_SETUP: begin
                    state         <= ST_STROBE;
                    strobe_second <= 1'b0;
                    if (word_rd[step]) begin
                        RD <= 1'b0;
                    end else begin
                        WR <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (!strobe_second) begin
                        strobe_second <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                        WR    <= 1'b1;
                        RD    <= 1'b1;
                        if (word_rd[step]) begin
                            rd_data <= dataBus_in;
                        end
                    end
                end
                ST_HOLD: begin
                    state      <= ST_GAP;
                    CS         <= 1'b1;
                    dataBus_oe <= 1'b0;
                end
                ST_GAP: begin
                    if (step != last_step) begin
                        state      <= ST_SETUP;
                        step       <= next_step;
                        CS         <= 1'b0;
                        A0         <= word_a0[next_step];
                        dataBus_oe <= ~word_rd[next_step];
                        if (!word_rd[next_step]) begin
                            dataBus_out <= word_data[next_step];
                        end
                    end else begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rd_valid <= word_rd[step];
                        if (seq_init) begin
                            init_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    CS    <= 1'b1;
                    WR    <= 1'b1;
                    RD    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: drives requests, logs every write
// and read strobe on the bus, and compares against hand-computed values.
module tb_pic_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_start, ocw_start, rd_start;
    logic [7:0] icw1, icw2, icw3, icw4, ocw_data, dataBus_in;
    logic [1:0] ocw_sel, rd_sel;
    logic [7:0] dataBus_out, rd_data;
    logic       dataBus_oe, A0, CS, WR, RD;
    logic       busy, done, init_done, err, rd_valid;

    always #5 clk = ~clk;

    pic_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .icw1       (icw1),
        .icw2       (icw2),
        .icw3       (icw3),
        .icw4       (icw4),
        .ocw_start  (ocw_start),
        .ocw_sel    (ocw_sel),
        .ocw_data   (ocw_data),
        .rd_start   (rd_start),
        .rd_sel     (rd_sel),
        .dataBus_in (dataBus_in),
        .dataBus_out(dataBus_out),
        .dataBus_oe (dataBus_oe),
        .A0         (A0),
        .CS         (CS),
        .WR         (WR),
        .RD         (RD),
        .busy       (busy),
        .done       (done),
        .init_done  (init_done),
        .err        (err),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bus monitor: log entry for a write is {oe, A0, data}
    logic [9:0] wlog [128];
    logic       rlog [128];
    int         w_n = 0, r_n = 0, cs_n = 0;
    logic       wr_q = 1'b1, rd_q = 1'b1;

    always @(negedge clk) begin
        if (CS === 1'b0) cs_n++;
        if (WR === 1'b0 && wr_q && w_n < 128) begin
            wlog[w_n] = {dataBus_oe, A0, dataBus_out};
            w_n++;
        end
        if (RD === 1'b0 && rd_q && r_n < 128) begin
            rlog[r_n] = A0;
            r_n++;
        end
        wr_q = (WR !== 1'b0);
        rd_q = (RD !== 1'b0);
    end

    int   done_cyc, wb, rb, cb;
    logic err_c1, busy_c1, initd_c1, rdv_done;

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_req(input logic i, input logic o, input logic r);
        wb = w_n; rb = r_n; cb = cs_n;
        init_start = i; ocw_start = o; rd_start = r;
        @(posedge clk); #1;
        init_start = 0; ocw_start = 0; rd_start = 0;
        done_cyc = 0; rdv_done = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                err_c1 = err; busy_c1 = busy; initd_c1 = init_done;
            end
            if (done) begin
                done_cyc = c; rdv_done = rd_valid;
                break;
            end
        end
        if (done_cyc == 0) check("done_timeout", 0, 1);
    endtask

    // A request that must be refused: err next clock, no bus activity.
    task automatic run_reject(input string tag, input logic o, input logic r);
        cb = cs_n;
        ocw_start = o; rd_start = r;
        @(posedge clk); #1;
        ocw_start = 0; rd_start = 0;
        @(negedge clk);
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        repeat (8) @(negedge clk);
        check({tag, "_no_cs"}, cs_n - cb, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; init_start = 0; ocw_start = 0; rd_start = 0;
        icw1 = 0; icw2 = 0; icw3 = 0; icw4 = 0;
        ocw_sel = 0; ocw_data = 0; rd_sel = 0; dataBus_in = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset_ctl", {CS, WR, RD, A0, dataBus_oe, busy, done, err, rd_valid, init_done},
              10'b1110000000);
        check("reset_dout", dataBus_out, 8'h00);
        check("reset_rd_data", rd_data, 8'h00);

        // OCW / read before init
        ocw_sel = 2'd1; ocw_data = 8'h55;
        run_reject("ocw_pre_init", 1, 0);
        rd_sel = 2'd2;
        run_reject("rd_pre_init", 0, 1);

        // Full ICW sequence
        icw1 = 8'h11; icw2 = 8'h40; icw3 = 8'h02; icw4 = 8'h1F;
        run_req(1, 0, 0);
        check("icw4_busy_c1", busy_c1, 1);
        check("icw4_writes", w_n - wb, 4);
        check("icw4_w0", wlog[wb],     10'h211);
        check("icw4_w1", wlog[wb + 1], 10'h340);
        check("icw4_w2", wlog[wb + 2], 10'h302);
        check("icw4_w3", wlog[wb + 3], 10'h31F);
        check("icw4_done_cyc", done_cyc, 21);
        @(negedge clk);
        check("icw4_init_done", init_done, 1);
        check("icw4_busy_after", busy, 0);
        check("icw4_done_pulse", done, 0);

        // ICW3 skipped, ICW4 upper bits forced low; re-init clears init_done
        icw1 = 8'h13; icw4 = 8'hE3;
        run_req(1, 0, 0);
        check("icw3skip_init_clr", initd_c1, 0);
        check("icw3skip_writes", w_n - wb, 3);
        check("icw3skip_w0", wlog[wb],     10'h213);
        check("icw3skip_w1", wlog[wb + 1], 10'h340);
        check("icw3skip_w2", wlog[wb + 2], 10'h303);
        check("icw3skip_done_cyc", done_cyc, 16);

        // ICW1+ICW2 only
        icw1 = 8'h02;
        run_req(1, 0, 0);
        check("icw2only_writes", w_n - wb, 2);
        check("icw2only_w0", wlog[wb],     10'h212);
        check("icw2only_w1", wlog[wb + 1], 10'h340);
        check("icw2only_done_cyc", done_cyc, 11);
        @(negedge clk);
        check("icw2only_init_done", init_done, 1);

        // ISR read
        rd_sel = 2'd1; dataBus_in = 8'h5A;
        run_req(0, 0, 1);
        check("isr_writes", w_n - wb, 1);
        check("isr_ocw3", wlog[wb], 10'h20B);
        check("isr_reads", r_n - rb, 1);
        check("isr_rd_a0", rlog[rb], 0);
        check("isr_done_cyc", done_cyc, 11);
        check("isr_rd_valid", rdv_done, 1);
        check("isr_rd_data", rd_data, 8'h5A);

        // IRR read
        rd_sel = 2'd0; dataBus_in = 8'h3C;
        run_req(0, 0, 1);
        check("irr_ocw3", wlog[wb], 10'h20A);
        check("irr_rd_a0", rlog[rb], 0);
        check("irr_rd_data", rd_data, 8'h3C);

        // IMR read
        rd_sel = 2'd2; dataBus_in = 8'hC3;
        run_req(0, 0, 1);
        check("imr_writes", w_n - wb, 0);
        check("imr_reads", r_n - rb, 1);
        check("imr_rd_a0", rlog[rb], 1);
        check("imr_done_cyc", done_cyc, 6);
        check("imr_rd_data", rd_data, 8'hC3);
        @(negedge clk);
        check("imr_rd_valid_pulse", rd_valid, 0);

        // OCW2 with a simultaneous read request: OCW wins, err once
        ocw_sel = 2'd2; ocw_data = 8'hFF; rd_sel = 2'd1; dataBus_in = 8'h00;
        run_req(0, 1, 1);
        check("ocw2_err_c1", err_c1, 1);
        check("ocw2_writes", w_n - wb, 1);
        check("ocw2_w0", wlog[wb], 10'h2E7);
        check("ocw2_reads", r_n - rb, 0);
        check("ocw2_done_cyc", done_cyc, 6);
        check("ocw2_no_rd_valid", rdv_done, 0);
        check("ocw2_rd_data_held", rd_data, 8'hC3);

        // OCW3 forced bits
        ocw_sel = 2'd3; ocw_data = 8'hFF;
        run_req(0, 1, 0);
        check("ocw3_w0", wlog[wb], 10'h26F);

        // Invalid selectors
        ocw_sel = 2'd0;
        run_reject("ocw_sel0", 1, 0);
        rd_sel = 2'd3;
        run_reject("rd_sel3", 0, 1);

        // OCW1 with a second start arriving while busy
        ocw_sel = 2'd1; ocw_data = 8'hA5;
        wb = w_n; done_cyc = 0;
        ocw_start = 1;
        @(posedge clk); #1;
        ocw_start = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 4) begin
                ocw_start = 0;
                check("busy_start_err", err, 1);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == 3) ocw_start = 1;
        end
        check("busy_start_done_cyc", done_cyc, 6);
        check("busy_start_writes", w_n - wb, 1);
        check("ocw1_w0", wlog[wb], 10'h3A5);

        // Reset during the first STROBE of ICW2
        icw1 = 8'h11; icw2 = 8'h40; icw3 = 8'h02; icw4 = 8'h1F;
        wb = w_n; cb = cs_n;
        init_start = 1;
        @(posedge clk); #1;
        init_start = 0;
        repeat (7) @(negedge clk);
        check("rst_mid_wr_low", WR, 0);
        reset = 1;
        @(negedge clk);
        check("rst_mid_wr", WR, 1);
        check("rst_mid_cs", CS, 1);
        check("rst_mid_init_done", init_done, 0);
        check("rst_mid_busy", busy, 0);
        reset = 0;
        repeat (20) @(negedge clk);
        check("rst_mid_strobes", w_n - wb, 2);
        check("rst_mid_cs_cycles", cs_n - cb, 6);
        check("rst_mid_idle", {CS, WR, RD, busy}, 4'b1110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pic_cmd_sequencer.md
PIC_CMD_SEQUENCER -- requirements
Module: pic_cmd_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 init_start  in  1  one-cycle request to issue the ICW sequence.
REQ-005 icw1, icw2, icw3, icw4  in  8 each  command word values, sampled on accepted init_start.
REQ-006 ocw_start  in  1  one-cycle request to issue one OCW; ocw_sel  in  2  (1=OCW1, 2=OCW2, 3=OCW3); ocw_data  in  8.
REQ-007 rd_start  in  1  one-cycle read request; rd_sel  in  2  (0=IRR, 1=ISR, 2=IMR).
REQ-008 dataBus_in  in  8  bus data from the PIC; dataBus_out  out  8; dataBus_oe  out  1  (1 = drive bus).
REQ-009 A0  out  1; CS, WR, RD  out  1 each, active-low.
REQ-010 busy  out  1; done  out  1 (one-cycle pulse); init_done  out  1 (level); err  out  1 (one-cycle pulse).
REQ-011 rd_data  out  8; rd_valid  out  1 (one-cycle pulse).

Function
REQ-012 Write cycle SHALL be 5 clocks: SETUP (CS=0, A0/data driven, oe=1, WR=1), STROBE x2 (WR=0), HOLD (WR=1, CS=0, data held), GAP (CS=1, oe=0).
REQ-013 Read cycle SHALL be 5 clocks: SETUP (CS=0, A0 driven, oe=0), STROBE x2 (RD=0), HOLD, GAP; dataBus_in is captured into rd_data on the second STROBE clock.
REQ-014 The first SETUP SHALL occur the clock after the start request is sampled.
REQ-015 ICW sequence: ICW1 (A0=0, bit4 forced 1), ICW2 (A0=1), ICW3 (A0=1) only if icw1[1]=0, ICW4 (A0=1, bits 7:5 forced 0) only if icw1[0]=1.
REQ-016 On completion of the ICW sequence, init_done SHALL go 1 and remain 1 until reset or a new init_start.
REQ-017 An accepted init_start SHALL clear init_done in the cycle after it is sampled.
REQ-018 OCW1 SHALL use A0=1 and unmodified data; OCW2 SHALL use A0=0 with bits 4:3 forced 00; OCW3 SHALL use A0=0 with bit7=0, bit4=0, bit3=1 forced.
REQ-019 IMR read SHALL be a single read cycle with A0=1.
REQ-020 IRR read SHALL be an OCW3 write of 0x0A, then a read cycle with A0=0.
REQ-021 ISR read SHALL be an OCW3 write of 0x0B, then a read cycle with A0=0.
REQ-022 rd_valid SHALL pulse with done at the end of a read; rd_data holds its value until the next capture.
REQ-023 done SHALL pulse, and busy SHALL fall, in the clock after the final GAP of a request.
REQ-024 busy SHALL be 1 from the clock after acceptance through the final GAP.
REQ-025 ocw_start or rd_start while init_done=0 SHALL be ignored and SHALL pulse err the next clock.
REQ-026 Any start while busy=1 SHALL be ignored and SHALL pulse err.
REQ-027 ocw_sel=0 or rd_sel=3 SHALL be ignored and SHALL pulse err.
REQ-028 Simultaneous starts in idle SHALL be prioritised init > ocw > rd; only the winner executes and err pulses once.
REQ-029 State machine states: IDLE, SETUP, STROBE, HOLD, GAP, with a step index selecting the next word.
REQ-030 GAP SHALL return to SETUP if words remain, else to IDLE.

Reset
REQ-031 On reset the block SHALL enter IDLE on the next edge with CS=WR=RD=1, A0=0, dataBus_oe=0, dataBus_out=0, busy=done=err=rd_valid=init_done=0, rd_data=0.
REQ-032 Reset SHALL override any in-flight cycle, including mid-STROBE, and no further strobe SHALL be issued.

Verification
REQ-033 init_start, icw1=0x11, icw2=0x40, icw3=0x02, icw4=0x1F -> 4 writes: (A0,data)=(0,0x11),(1,0x40),(1,0x02),(1,0x1F); done at clock 21; init_done=1.
REQ-034 init_start, icw1=0x13, icw4=0xE3 -> 3 writes: ICW3 skipped, ICW4 sent as 0x03; icw1=0x02 -> 2 writes only.
REQ-035 After init, rd_start, rd_sel=1, dataBus_in=0x5A -> OCW3 write 0x0B (A0=0), then read with A0=0; rd_data=0x5A; rd_valid at clock 11.
REQ-036 ocw_start before init -> no CS activity, err pulse; ocw_start during an active write -> ignored, err pulse.
REQ-037 After init, ocw_start, ocw_sel=2, ocw_data=0xFF -> A0=0, bus 0xE7; same clock rd_start -> not executed, err pulse.
REQ-038 reset asserted during the first STROBE of ICW2 -> WR=1, CS=1 next clock; init_done=0; no further bus activity.
